// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave datapath (master side) and the
// frame controller (slave side): frame events, received bytes, next TX byte.
interface spi_reg_ctrl_if;
  logic       msg_start;
  logic       msg_end;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (output msg_start, msg_end, rx_valid, rx_byte, input  tx_byte);
  modport slave  (input  msg_start, msg_end, rx_valid, rx_byte, output tx_byte);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI frame controller: command/address byte then data bytes with address
// auto-increment, over a small register bank; supplies the next MISO byte.
module spi_reg_ctrl #(
  parameter int         NREGS     = 8,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] ID_VAL    = 8'hA7,
  parameter logic [7:0] SYNC_VAL  = 8'h5A
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_ctrl_if.slave        bus,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [8*NREGS-1:0]   regs_out,
  output logic [7:0]           frame_cnt,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  localparam logic [7:0] NREGS_L = 8'(NREGS);

  state_t                  state, state_nxt, state_byte;
  logic [6:0]              addr, addr_nxt;
  logic [7:0]              tx_q, tx_nxt;
  logic [NREGS-1:0][7:0]   bank;
  logic                    we, cnt_inc;

  // ID address outranks the bank so it stays readable for any NREGS.
  function automatic logic [7:0] rd_fn(input logic [6:0] a, input logic [NREGS-1:0][7:0] b);
    rd_fn = 8'h00;
    for (int i = 0; i < NREGS; i++)
      if (a == 7'(i)) rd_fn = b[i];
    if (a == 7'h7F) rd_fn = ID_VAL;
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // state_byte is where the frame stands after this cycle's byte, so a
  // same-cycle msg_end sees the post-byte state.
  always_comb begin
    state_byte = state;
    if (bus.rx_valid && state == CMD)
      state_byte = bus.rx_byte[7] ? RD : WR;
    state_nxt = state_byte;
    if (bus.msg_start)                      state_nxt = CMD;
    else if (bus.msg_end && state != IDLE)  state_nxt = IDLE;
  end

  always_comb begin
    addr_nxt = addr;
    tx_nxt   = tx_q;
    we       = 1'b0;
    cnt_inc  = 1'b0;
    if (bus.msg_start) begin
      tx_nxt = SYNC_VAL;
    end else begin
      if (bus.rx_valid) begin
        case (state)
          CMD: begin
            addr_nxt = bus.rx_byte[6:0];
            tx_nxt   = bus.rx_byte[7] ? rd_fn(bus.rx_byte[6:0], bank) : 8'h00;
          end
          WR: begin
            we       = ({1'b0, addr} < NREGS_L);
            addr_nxt = addr + 7'd1;
          end
          RD: begin
            addr_nxt = addr + 7'd1;
            tx_nxt   = rd_fn(addr + 7'd1, bank);
          end
          default: ;
        endcase
      end
      if (bus.msg_end && state != IDLE) begin
        tx_nxt  = SYNC_VAL;
        cnt_inc = (state_byte == WR) || (state_byte == RD);
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_q      <= SYNC_VAL;
      addr      <= 7'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      frame_cnt <= 8'd0;
      for (int i = 0; i < NREGS; i++) bank[i] <= RESET_VAL;
    end else begin
      tx_q      <= tx_nxt;
      addr      <= addr_nxt;
      wr_strobe <= we;
      frame_cnt <= frame_cnt + 8'(cnt_inc);
      if (we) wr_addr <= addr;
      for (int i = 0; i < NREGS; i++)
        if (we && addr == 7'(i)) bank[i] <= bus.rx_byte;
    end

  assign bus.tx_byte = tx_q;
  assign regs_out    = bank;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus pushes expected TX loads and
// register writes; monitors pop and compare as the DUT presents them.
module tb_spi_reg_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [63:0] regs_out;
  logic [7:0]  frame_cnt;
  logic        busy;

  always #5 clk = ~clk;

  spi_reg_ctrl_if bus();

  spi_reg_ctrl #(.NREGS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .regs_out(regs_out),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  txq[$];
  logic [14:0] wq[$];
  logic [1:0]  samp_d;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The datapath loads tx_byte after each frame event; sample once it settles.
  always @(posedge clk or posedge rst)
    if (rst) samp_d <= 2'b00;
    else     samp_d <= {samp_d[0], bus.msg_start | bus.msg_end | bus.rx_valid};

  always @(negedge clk) begin : tx_mon
    logic [7:0] e;
    if (samp_d[1]) begin
      if (txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %0h with no expected load", bus.tx_byte);
      end else begin
        e = txq.pop_front();
        chk("tx_byte", 64'(bus.tx_byte), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : wr_mon
    logic [14:0] w;
    int a;
    if (!rst && wr_strobe) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got strobe addr %0h with none expected", wr_addr);
      end else begin
        w = wq.pop_front();
        a = int'(w[14:8]);
        chk("wr_addr", 64'(wr_addr), 64'(w[14:8]));
        chk("wr_data", 64'(regs_out[a*8 +: 8]), 64'(w[7:0]));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ev(logic s, logic e, logic v, logic [7:0] b, logic [7:0] exp_tx);
    txq.push_back(exp_tx);
    @(negedge clk);
    bus.msg_start = s; bus.msg_end = e; bus.rx_valid = v; bus.rx_byte = b;
    @(negedge clk);
    bus.msg_start = 1'b0; bus.msg_end = 1'b0; bus.rx_valid = 1'b0;
    cyc(4);
  endtask

  task automatic start();                           ev(1'b1, 1'b0, 1'b0, 8'h00, 8'h5A); endtask
  task automatic stop();                            ev(1'b0, 1'b1, 1'b0, 8'h00, 8'h5A); endtask
  task automatic send(logic [7:0] b, logic [7:0] t); ev(1'b0, 1'b0, 1'b1, b, t);        endtask
  task automatic wr(logic [6:0] a, logic [7:0] d);   wq.push_back({a, d});              endtask

  initial begin
    bus.msg_start = 1'b0; bus.msg_end = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    cyc(2);
    chk("rst_tx", 64'(bus.tx_byte), 64'h5A);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cnt", 64'(frame_cnt), 64'h0);
    chk("rst_regs", regs_out, 64'h0);
    chk("rst_strobe", 64'(wr_strobe), 64'h0);
    chk("rst_waddr", 64'(wr_addr), 64'h0);
    rst = 1'b0;
    cyc(2);

    // Write 0x11,0x22,0x33 starting at reg2
    start();
    chk("busy_cmd", 64'(busy), 64'h1);
    send(8'h02, 8'h00);
    wr(7'd2, 8'h11); send(8'h11, 8'h00);
    wr(7'd3, 8'h22); send(8'h22, 8'h00);
    wr(7'd4, 8'h33); send(8'h33, 8'h00);
    stop();
    chk("cnt_f1", 64'(frame_cnt), 64'd1);
    chk("regs_f1", regs_out, 64'h0000003322110000);

    // Read back from reg2
    start();
    send(8'h82, 8'h11);
    send(8'h00, 8'h22);
    send(8'h00, 8'h33);
    send(8'h00, 8'h00);
    stop();
    chk("cnt_f2", 64'(frame_cnt), 64'd2);
    chk("regs_f2", regs_out, 64'h0000003322110000);

    // Give reg0 a distinct value, then read ID and wrap to reg0
    start(); send(8'h00, 8'h00); wr(7'd0, 8'hC3); send(8'hC3, 8'h00); stop();
    start(); send(8'hFF, 8'hA7); send(8'h00, 8'hC3); stop();
    start(); send(8'h90, 8'h00); send(8'h00, 8'h00); stop();
    chk("cnt_f5", 64'(frame_cnt), 64'd5);

    // Write past the bank end: address 8 dropped
    start(); send(8'h07, 8'h00);
    wr(7'd7, 8'hAA); send(8'hAA, 8'h00);
    send(8'hBB, 8'h00);
    stop();
    chk("regs_f6", regs_out, 64'hAA000033221100C3);
    chk("cnt_f6", 64'(frame_cnt), 64'd6);

    // Empty frame is not counted
    start(); stop();
    chk("cnt_empty", 64'(frame_cnt), 64'd6);
    chk("busy_empty", 64'(busy), 64'h0);

    // Restart mid-WR: next byte is a command (read reg4)
    start(); send(8'h01, 8'h00);
    wr(7'd1, 8'h44); send(8'h44, 8'h00);
    start();
    send(8'h84, 8'h33);
    stop();
    chk("regs_restart", regs_out, 64'hAA000033221144C3);
    chk("cnt_restart", 64'(frame_cnt), 64'd7);

    // msg_end with the last byte
    start(); send(8'h05, 8'h00);
    wr(7'd5, 8'h66); ev(1'b0, 1'b1, 1'b1, 8'h66, 8'h5A);
    chk("cnt_endbyte", 64'(frame_cnt), 64'd8);
    chk("busy_endbyte", 64'(busy), 64'h0);

    // msg_start beats rx_valid; then back-to-back bytes
    ev(1'b1, 1'b0, 1'b1, 8'h83, 8'h5A);
    send(8'h06, 8'h00);
    wr(7'd6, 8'h12); wr(7'd7, 8'h34);
    txq.push_back(8'h00); txq.push_back(8'h00);
    @(negedge clk); bus.rx_valid = 1'b1; bus.rx_byte = 8'h12;
    @(negedge clk); bus.rx_byte = 8'h34;
    @(negedge clk); bus.rx_valid = 1'b0;
    cyc(4);
    stop();
    chk("regs_b2b", regs_out, 64'h34126633221144C3);
    chk("cnt_b2b", 64'(frame_cnt), 64'd9);

    // Async reset mid-WR
    start(); send(8'h03, 8'h00);
    wr(7'd3, 8'h77); send(8'h77, 8'h00);
    chk("busy_wr", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_regs", regs_out, 64'h0);
    chk("mid_rst_tx", 64'(bus.tx_byte), 64'h5A);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'h0);
    @(negedge clk); rst = 1'b0;
    cyc(2);

    start(); send(8'h01, 8'h00);
    wr(7'd1, 8'h9D); send(8'h9D, 8'h00);
    stop();
    chk("regs_post", regs_out, 64'h0000000000009D00);
    chk("cnt_post", 64'(frame_cnt), 64'd1);

    cyc(4);
    chk("txq_left", 64'(txq.size()), 64'd0);
    chk("wq_left", 64'(wq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
